// File: rtl/stm32_bus_master_if.sv
// Byte-wide STM32<->FPGA command bus pad signals, split into drive, enable and sample.
// The master drives DATA_SYNC/BUS_OUT/BUS_OE; the slave side returns BUS_IN.
interface stm32_bus_master_if;
    logic       DATA_SYNC;
    logic [7:0] BUS_OUT;
    logic       BUS_OE;
    logic [7:0] BUS_IN;

    modport master (output DATA_SYNC, output BUS_OUT, output BUS_OE, input BUS_IN);
    modport slave  (input DATA_SYNC, input BUS_OUT, input BUS_OE, output BUS_IN);
endinterface

// File: rtl/stm32_bus_master.sv
// Initiator for the STM32<->FPGA command bus: command byte with DATA_SYNC, then a
// fixed-length write stream from a show-ahead FIFO or a read capture, then an idle gap.
module stm32_bus_master #(
    parameter int GAP     = 1,
    parameter int RD_SKIP = 1
) (
    input  logic                clk_in,
    input  logic                reset_n,
    input  logic                start,
    input  logic [7:0]          cmd,
    input  logic [7:0]          wr_len,
    input  logic [15:0]         rd_len,
    output logic                busy,
    output logic                done,
    output logic                cmd_err,
    input  logic [7:0]          wr_data,
    input  logic                wr_empty,
    output logic                wr_pop,
    output logic [7:0]          rd_data,
    output logic                rd_valid,
    output logic                underrun,
    stm32_bus_master_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WRITE,
        S_TURN,
        S_READ,
        S_GAP
    } state_t;

    localparam logic [3:0] GAP_INIT  = 4'(GAP - 1);
    localparam logic [3:0] TURN_INIT = 4'(RD_SKIP - 1);

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [3:0]  gcnt, gcnt_n;
    logic        is_wr, is_wr_n;
    logic        is_rd, is_rd_n;
    logic        busy_n, done_n, cmd_err_n, rd_valid_n, underrun_n;
    logic [7:0]  rd_data_n;
    logic        sync_r, sync_n;
    logic [7:0]  bus_out_r, bus_out_n;
    logic        bus_oe_r, bus_oe_n;
    logic        load, enter_gap;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= 16'd0;
            gcnt      <= 4'd0;
            is_wr     <= 1'b0;
            is_rd     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
            rd_data   <= 8'h00;
            rd_valid  <= 1'b0;
            underrun  <= 1'b0;
            sync_r    <= 1'b0;
            bus_out_r <= 8'h00;
            bus_oe_r  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            gcnt      <= gcnt_n;
            is_wr     <= is_wr_n;
            is_rd     <= is_rd_n;
            busy      <= busy_n;
            done      <= done_n;
            cmd_err   <= cmd_err_n;
            rd_data   <= rd_data_n;
            rd_valid  <= rd_valid_n;
            underrun  <= underrun_n;
            sync_r    <= sync_n;
            bus_out_r <= bus_out_n;
            bus_oe_r  <= bus_oe_n;
        end
    end

    // cnt holds bytes still to load (write) or still to sample (read); gcnt serves turnaround and gap.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        gcnt_n     = gcnt;
        is_wr_n    = is_wr;
        is_rd_n    = is_rd;
        busy_n     = busy;
        done_n     = 1'b0;
        cmd_err_n  = 1'b0;
        rd_data_n  = rd_data;
        rd_valid_n = 1'b0;
        underrun_n = underrun;
        sync_n     = 1'b0;
        bus_out_n  = 8'h00;
        bus_oe_n   = 1'b0;
        load       = 1'b0;
        enter_gap  = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy_n = 1'b0;
                if (start) begin
                    if (wr_len != 8'd0 && rd_len != 16'd0) begin
                        cmd_err_n = 1'b1;
                    end else begin
                        state_n    = S_CMD;
                        busy_n     = 1'b1;
                        sync_n     = 1'b1;
                        bus_oe_n   = 1'b1;
                        bus_out_n  = cmd;
                        underrun_n = 1'b0;
                        is_wr_n    = (wr_len != 8'd0);
                        is_rd_n    = (rd_len != 16'd0);
                        cnt_n      = (wr_len != 8'd0) ? {8'h00, wr_len} : rd_len;
                    end
                end
            end
            S_CMD: begin
                if (is_wr) begin
                    load = 1'b1;
                end else if (is_rd) begin
                    if (RD_SKIP == 0) begin
                        state_n = S_READ;
                    end else begin
                        state_n = S_TURN;
                        gcnt_n  = TURN_INIT;
                    end
                end else begin
                    enter_gap = 1'b1;
                end
            end
            S_WRITE: begin
                if (cnt == 16'd0) enter_gap = 1'b1;
                else              load      = 1'b1;
            end
            S_TURN: begin
                if (gcnt == 4'd0) state_n = S_READ;
                else              gcnt_n  = gcnt - 4'd1;
            end
            S_READ: begin
                rd_data_n  = bus.BUS_IN;
                rd_valid_n = 1'b1;
                cnt_n      = cnt - 16'd1;
                if (cnt == 16'd1) enter_gap = 1'b1;
            end
            S_GAP: begin
                if (gcnt == 4'd0) begin
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                end else begin
                    gcnt_n = gcnt - 4'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // The slave advances every clock, so an empty FIFO yields a zero byte instead of a stall.
        if (load) begin
            state_n   = S_WRITE;
            cnt_n     = cnt - 16'd1;
            bus_oe_n  = 1'b1;
            bus_out_n = wr_empty ? 8'h00 : wr_data;
            if (wr_empty) underrun_n = 1'b1;
        end
        if (enter_gap) begin
            state_n = S_GAP;
            gcnt_n  = GAP_INIT;
            done_n  = 1'b1;
        end
    end

    assign wr_pop        = load & ~wr_empty;
    assign bus.DATA_SYNC = sync_r;
    assign bus.BUS_OUT   = bus_out_r;
    assign bus.BUS_OE    = bus_oe_r;

endmodule

// File: tb/tb_stm32_bus_master.sv
// Randomized self-checking bench for stm32_bus_master against a cycle-indexed model
// that derives every output from the transaction parameters and the bus-cycle number.
module tb_stm32_bus_master;

    localparam int TB_GAP  = 2;
    localparam int TB_SKIP = 1;

    logic        clk_in  = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic [7:0]  cmd     = 8'h00;
    logic [7:0]  wr_len  = 8'h00;
    logic [15:0] rd_len  = 16'h0000;
    logic        busy, done, cmd_err, wr_pop, rd_valid, underrun, wr_empty;
    logic [7:0]  wr_data, rd_data;

    stm32_bus_master_if bus_if();

    stm32_bus_master #(.GAP(TB_GAP), .RD_SKIP(TB_SKIP)) dut (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .start    (start),
        .cmd      (cmd),
        .wr_len   (wr_len),
        .rd_len   (rd_len),
        .busy     (busy),
        .done     (done),
        .cmd_err  (cmd_err),
        .wr_data  (wr_data),
        .wr_empty (wr_empty),
        .wr_pop   (wr_pop),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .underrun (underrun),
        .bus      (bus_if)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;

    // Show-ahead FIFO: the stimulus appends, the pop side advances on wr_pop.
    logic [7:0] fifo_mem [0:4095];
    int         fifo_wp = 0;
    int         fifo_rp = 0;
    int         fifo_avail = 0;
    assign wr_empty = (fifo_rp == fifo_wp);
    assign wr_data  = wr_empty ? 8'h00 : fifo_mem[fifo_rp % 4096];

    always @(posedge clk_in) begin
        if (wr_pop && !wr_empty) fifo_rp <= fifo_rp + 1;
    end

    logic [7:0] wr_src   [0:255];
    logic [7:0] exp_wr   [0:255];
    logic [7:0] slave_rd [0:2047];

    // Model state: whether a transaction is in flight and which bus cycle it is in.
    bit         m_active = 1'b0;
    int         m_k      = 0;
    logic [7:0] m_cmd    = 8'h00;
    int         m_wl     = 0;
    int         m_rl     = 0;
    int         m_avail  = 0;
    int         m_T      = 0;
    bit         m_err    = 1'b0;
    bit         m_und    = 1'b0;

    always @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_err    <= 1'b0;
            m_und    <= 1'b0;
        end else begin
            m_err <= 1'b0;
            if (m_active) begin
                if (m_wl != 0 && m_k < m_wl && m_k >= m_avail) m_und <= 1'b1;
                if (m_k == m_T + TB_GAP) m_active <= 1'b0;
                else                     m_k      <= m_k + 1;
            end else if (start) begin
                if (wr_len != 8'd0 && rd_len != 16'd0) begin
                    m_err <= 1'b1;
                end else begin
                    m_active <= 1'b1;
                    m_k      <= 0;
                    m_cmd    <= cmd;
                    m_wl     <= int'(wr_len);
                    m_rl     <= int'(rd_len);
                    m_avail  <= fifo_avail;
                    m_und    <= 1'b0;
                    m_T      <= (wr_len != 8'd0) ? int'(wr_len) :
                                (rd_len != 16'd0) ? TB_SKIP + int'(rd_len) : 0;
                end
            end
        end
    end

    // Slave side: present read byte i during bus cycle 1+RD_SKIP+i, noise otherwise.
    always @(negedge clk_in) begin
        if (m_active && m_wl == 0 && m_rl != 0 && m_k >= 1 + TB_SKIP && m_k <= TB_SKIP + m_rl)
            bus_if.BUS_IN = slave_rd[m_k - 1 - TB_SKIP];
        else
            bus_if.BUS_IN = 8'($urandom);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic       e_busy, e_sync, e_oe, e_done, e_rv, e_pop;
    logic [7:0] e_bus, e_rd;
    int         cnt_pop = 0, cnt_sync = 0, cnt_done = 0, cnt_err = 0;
    logic [7:0] rd_seen [$];
    int         rv_k    [$];
    logic [7:0] wr_seen [$];

    always @(negedge clk_in) begin
        e_busy = 1'b0; e_sync = 1'b0; e_oe = 1'b0; e_done = 1'b0;
        e_rv = 1'b0; e_pop = 1'b0; e_bus = 8'h00; e_rd = 8'h00;
        if (m_active) begin
            e_busy = 1'b1;
            e_sync = (m_k == 0);
            e_oe   = (m_k == 0) || (m_wl != 0 && m_k <= m_wl);
            if (m_k == 0)                                e_bus = m_cmd;
            else if (m_wl != 0 && m_k <= m_wl)           e_bus = exp_wr[m_k - 1];
            e_done = (m_k == m_T + 1);
            e_rv   = (m_wl == 0 && m_rl != 0 && m_k >= 2 + TB_SKIP && m_k <= 1 + TB_SKIP + m_rl);
            if (e_rv) e_rd = slave_rd[m_k - 2 - TB_SKIP];
            e_pop  = (m_wl != 0 && m_k < m_wl && m_k < m_avail);
        end
        checkOutput("busy",      32'(busy),           32'(e_busy));
        checkOutput("data_sync", 32'(bus_if.DATA_SYNC), 32'(e_sync));
        checkOutput("bus_oe",    32'(bus_if.BUS_OE),  32'(e_oe));
        checkOutput("bus_out",   32'(bus_if.BUS_OUT), 32'(e_bus));
        checkOutput("done",      32'(done),           32'(e_done));
        checkOutput("rd_valid",  32'(rd_valid),       32'(e_rv));
        checkOutput("wr_pop",    32'(wr_pop),         32'(e_pop));
        checkOutput("cmd_err",   32'(cmd_err),        32'(m_err));
        checkOutput("underrun",  32'(underrun),       32'(m_und));
        if (e_rv || !reset_n) checkOutput("rd_data", 32'(rd_data), 32'(e_rd));
        if (wr_pop) cnt_pop++;
        if (bus_if.DATA_SYNC) cnt_sync++;
        if (done) cnt_done++;
        if (cmd_err) cnt_err++;
        if (rd_valid) begin
            rd_seen.push_back(rd_data);
            rv_k.push_back(m_k);
        end
        if (bus_if.BUS_OE && !bus_if.DATA_SYNC) wr_seen.push_back(bus_if.BUS_OUT);
    end

    // Runs one transaction; abort_at>0 pulls reset in that bus cycle instead of completing.
    task automatic applyStimulus(input logic [7:0] c, input logic [7:0] wl, input logic [15:0] rl,
                                 input int navail, input bit poke, input int abort_at);
        int budget;
        @(negedge clk_in);
        for (int i = 0; i < navail; i++) begin
            fifo_mem[fifo_wp % 4096] = wr_src[i];
            fifo_wp++;
        end
        for (int i = 0; i < int'(wl); i++) exp_wr[i] = (i < navail) ? wr_src[i] : 8'h00;
        fifo_avail = navail;
        cmd = c; wr_len = wl; rd_len = rl; start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        cmd = 8'($urandom); wr_len = 8'($urandom); rd_len = 16'($urandom);
        if (poke && m_active) begin
            start = 1'b1;
            @(negedge clk_in);
            start = 1'b0;
        end
        budget = 0;
        if (abort_at > 0) begin
            while (m_active && m_k != abort_at && budget < 3000) begin
                @(negedge clk_in);
                budget++;
            end
            checkOutput("abort_reached", 32'(m_k), 32'(abort_at));
            #2 reset_n = 1'b0;
            #1;
            checkOutput("abort_busy",     32'(busy),             0);
            checkOutput("abort_sync",     32'(bus_if.DATA_SYNC), 0);
            checkOutput("abort_oe",       32'(bus_if.BUS_OE),    0);
            checkOutput("abort_rd_valid", 32'(rd_valid),         0);
            checkOutput("abort_rd_data",  32'(rd_data),          0);
            repeat (3) @(negedge clk_in);
            #2 reset_n = 1'b1;
        end else begin
            while (m_active && budget < 3000) begin
                @(negedge clk_in);
                budget++;
            end
            if (m_active) begin
                tests++;
                fails++;
                $display("[TB] FAIL timeout: transaction still active after %0d cycles", budget);
            end
        end
        @(negedge clk_in);
        #1;
    endtask

    int         b_pop, b_sync, b_done, b_err, b_rd, b_wr;
    logic [7:0] lit [0:6];

    task automatic snapshot();
        b_pop = cnt_pop; b_sync = cnt_sync; b_done = cnt_done; b_err = cnt_err;
        b_rd = rd_seen.size(); b_wr = wr_seen.size();
    endtask

    initial begin
        repeat (3) @(negedge clk_in);
        #1;
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_sync", 32'(bus_if.DATA_SYNC), 0);
        checkOutput("rst_bus",  32'(bus_if.BUS_OUT), 0);
        checkOutput("rst_rd",   32'(rd_data), 0);
        @(negedge clk_in);
        #2 reset_n = 1'b1;

        // GET PARAMS: 24 bytes, NCO1 bytes at the front of the FIFO.
        lit[0] = 8'h07; lit[1] = 8'h00; lit[2] = 8'h03; lit[3] = 8'hB2; lit[4] = 8'h6B;
        for (int i = 0; i < 24; i++) wr_src[i] = (i < 5) ? lit[i] : 8'($urandom);
        snapshot();
        applyStimulus(8'd1, 8'd24, 16'd0, 24, 1'b0, 0);
        checkOutput("gp_pops", 32'(cnt_pop - b_pop), 24);
        checkOutput("gp_sync", 32'(cnt_sync - b_sync), 1);
        checkOutput("gp_done", 32'(cnt_done - b_done), 1);
        checkOutput("gp_nbytes", 32'(wr_seen.size() - b_wr), 24);
        for (int i = 0; i < 5; i++) checkOutput("gp_byte", 32'(wr_seen[b_wr + i]), 32'(lit[i]));

        // SEND PARAMS: seven read bytes, first rd_valid in bus cycle 3.
        lit[0] = 8'h01; lit[1] = 8'h81; lit[2] = 8'h23; lit[3] = 8'h7E;
        lit[4] = 8'hDC; lit[5] = 8'h00; lit[6] = 8'h10;
        for (int i = 0; i < 7; i++) slave_rd[i] = lit[i];
        snapshot();
        applyStimulus(8'd2, 8'd0, 16'd7, 0, 1'b0, 0);
        checkOutput("sp_count", 32'(rd_seen.size() - b_rd), 7);
        for (int i = 0; i < 7; i++) checkOutput("sp_byte", 32'(rd_seen[b_rd + i]), 32'(lit[i]));
        checkOutput("sp_first_cycle", 32'(rv_k[b_rd]), 3);

        // Single-byte command with a start pulse while busy.
        snapshot();
        applyStimulus(8'd5, 8'd0, 16'd0, 0, 1'b1, 0);
        checkOutput("c5_sync", 32'(cnt_sync - b_sync), 1);
        checkOutput("c5_done", 32'(cnt_done - b_done), 1);

        // TX IQ with only four bytes available.
        for (int i = 0; i < 4; i++) wr_src[i] = 8'($urandom_range(1, 255));
        snapshot();
        applyStimulus(8'd3, 8'd6, 16'd0, 4, 1'b0, 0);
        checkOutput("tx_pops", 32'(cnt_pop - b_pop), 4);
        checkOutput("tx_byte5", 32'(wr_seen[b_wr + 4]), 0);
        checkOutput("tx_byte6", 32'(wr_seen[b_wr + 5]), 0);
        checkOutput("tx_underrun", 32'(underrun), 1);

        // Both lengths non-zero: rejected.
        snapshot();
        applyStimulus(8'd4, 8'd6, 16'd6, 0, 1'b0, 0);
        checkOutput("err_pulse", 32'(cnt_err - b_err), 1);
        checkOutput("err_sync", 32'(cnt_sync - b_sync), 0);
        checkOutput("err_underrun_kept", 32'(underrun), 1);

        // RX IQ aborted by reset in bus cycle 500.
        for (int i = 0; i < 1200; i++) slave_rd[i] = 8'($urandom);
        snapshot();
        applyStimulus(8'd4, 8'd0, 16'd1200, 0, 1'b0, 500);
        repeat (4) @(negedge clk_in);
        #1;
        checkOutput("abort_no_done", 32'(cnt_done - b_done), 0);

        lit[0] = 8'h06; lit[1] = 8'h08; lit[2] = 8'h00;
        for (int i = 0; i < 3; i++) slave_rd[i] = lit[i];
        snapshot();
        applyStimulus(8'd8, 8'd0, 16'd3, 0, 1'b0, 0);
        checkOutput("c8_count", 32'(rd_seen.size() - b_rd), 3);
        for (int i = 0; i < 3; i++) checkOutput("c8_byte", 32'(rd_seen[b_rd + i]), 32'(lit[i]));

        // Random mix of write, read, single-byte and rejected transactions.
        for (int t = 0; t < 30; t++) begin
            int mode, wl, rl, av;
            mode = int'($urandom_range(0, 3));
            wl = 0; rl = 0; av = 0;
            case (mode)
                0: begin wl = int'($urandom_range(1, 20)); av = int'($urandom_range(0, wl)); end
                1: rl = int'($urandom_range(1, 16));
                3: begin wl = int'($urandom_range(1, 20)); rl = int'($urandom_range(1, 16)); end
                default: ;
            endcase
            for (int i = 0; i < wl; i++) wr_src[i] = 8'($urandom);
            for (int i = 0; i < rl; i++) slave_rd[i] = 8'($urandom);
            applyStimulus(8'($urandom_range(0, 10)), 8'(wl), 16'(rl), (mode == 3) ? 0 : av,
                          1'($urandom_range(0, 1)), 0);
            repeat (int'($urandom_range(0, 3))) @(negedge clk_in);
        end

        repeat (3) @(negedge clk_in);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stm32_bus_master.md
Name: stm32_bus_master

Overview:
- Initiator side of the byte-wide STM32<->FPGA command bus: drives DATA_SYNC plus a command byte, then streams write bytes or captures read bytes, one byte per clk_in cycle.
- Counterpart of the FPGA slave interface. Used as a soft host in system benches and as the bridge for an on-FPGA controller that must program NCO, gain and divider parameters or pull RX IQ without the MCU.
- Bus data is split into separate out, oe and in ports; the top level or bench owns the tristate/pad.

Parameters:
GAP, 1, idle cycles (DATA_SYNC=0, BUS_OE=0) forced after every transaction before the next start is accepted; range 1..15.
RD_SKIP, 1, bus cycles after the command cycle before the first read byte is sampled (slave output turnaround).

Ports:
clk_in  in  1  bus clock, shared with slave
reset_n  in  1  async active-low reset
start  in  1  begin transaction; sampled only when busy=0
cmd  in  8  command byte (0..10 per bus protocol)
wr_len  in  8  bytes to write after command (GET PARAMS=24, TX IQ=6)
rd_len  in  16  bytes to read after command (SEND PARAMS=7, GET INFO=3, RX IQ=6*N or 12*N)
busy  out  1  transaction or gap in progress
done  out  1  one-cycle pulse at end of transaction
cmd_err  out  1  one-cycle pulse: start rejected
wr_data  in  8  write byte from show-ahead FIFO
wr_empty  in  1  FIFO empty
wr_pop  out  1  consume wr_data this cycle
rd_data  out  8  captured read byte
rd_valid  out  1  rd_data valid this cycle
underrun  out  1  sticky; cleared on accepted start
DATA_SYNC  out  1  frame strobe to slave
BUS_OUT  out  8  bus drive value
BUS_OE  out  1  1 = master drives bus
BUS_IN  in  8  bus sample

Behaviour:
- Reset (async, reset_n=0): state IDLE. All outputs 0: busy, done, cmd_err, wr_pop, rd_valid, underrun, DATA_SYNC, BUS_OE, BUS_OUT=0x00, rd_data=0x00. Reset mid-transaction aborts immediately; no done pulse.
- All bus outputs are registered. "Bus cycle n" means the period after the nth edge following acceptance.
- State machine: IDLE -> CMD -> (WRITE | TURN -> READ | none) -> GAP -> IDLE.
- IDLE:
  - start=1 with wr_len!=0 and rd_len!=0: no transaction; cmd_err pulses next cycle; busy stays 0.
  - Otherwise latch cmd, wr_len and rd_len; clear underrun; busy=1; go to CMD.
- CMD (bus cycle 0): DATA_SYNC=1, BUS_OE=1, BUS_OUT=cmd.
  - wr_len!=0 -> WRITE.
  - rd_len!=0 -> TURN.
  - Both 0 -> GAP. Single-byte commands 5, 6, 9, 10 take this path.
- WRITE (bus cycles 1..wr_len): DATA_SYNC=0, BUS_OE=1. Byte i is on the bus in cycle 1+i.
  - wr_pop=1 on the edge that loads BUS_OUT from wr_data.
  - If wr_empty at that edge: drive 0x00, wr_pop=0, set underrun. The transfer never stalls, because the slave advances every clock.
- TURN: BUS_OE=0 from bus cycle 1 onward. Wait RD_SKIP cycles.
- READ: sample BUS_IN at the end of bus cycle 1+RD_SKIP+i for i=0..rd_len-1. rd_data/rd_valid are registered and present one cycle after each sample. rd_len up to 65535 supports continuous RX IQ streaming.
- GAP: DATA_SYNC=0, BUS_OE=0, BUS_OUT=0x00 for GAP cycles.
  - done pulses in the first GAP cycle.
  - busy falls at the end of the last GAP cycle.
  - start is ignored whenever busy=1.
- Counters: 16-bit down-counter for the byte count, 4-bit counter for the gap. No wrap: a transaction ends exactly at count 0.
- DATA_SYNC is high for exactly one cycle per transaction and never high while BUS_OE=0.

Test Plan:
- GET PARAMS: cmd=1, wr_len=24, FIFO preloaded 0x07,0x00,0x03,0xB2,0x6B,...
  -> cycle 0 sync=1, bus=0x01; cycles 1..24 carry the bytes in order; 24 wr_pop pulses; done at cycle 25; slave model NCO1_freq=0x0003B26B, rx1=rx2=tx=1.
- SEND PARAMS: cmd=2, rd_len=7, slave model returns flags=0x01, ADC_MIN=0x8123, ADC_MAX=0x7EDC, RAW=0x0010
  -> rd_data sequence 01,81,23,7E,DC,00,10; first rd_valid at cycle 3; BUS_OE=0 from cycle 1.
- cmd=5, wr_len=0, rd_len=0
  -> one sync cycle; done in cycle 1; busy low after GAP.
  - A start pulsed during busy is ignored: no second sync.
- TX IQ: cmd=3, wr_len=6, FIFO holds only 4 bytes
  -> bytes 5-6 driven 0x00; 4 wr_pops; underrun=1 until the next start.
- RX IQ: cmd=4, rd_len=1200, reset_n low at cycle 500
  -> all outputs 0 immediately; no done.
  - After reset release, cmd=8 with rd_len=3 returns 06,08,00.
- start with wr_len=6 and rd_len=6
  -> cmd_err pulse; DATA_SYNC stays 0; busy stays 0.
